tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Generates the game's update ticks from one free-running prescaler, replacing the use of raw divided-clock bits as clocks.
- Provides NUM_CH independently programmable periodic channels (player, car lanes, animation).
- Pending channel events are arbitrated round-robin onto a single grant/ready handshake that drives the shared object-update logic.
- Everything runs on the single system clock; no derived clocks.

Parameters:
- NUM_CH, 4, number of tick channels (2..8)
- PRESC_W, 17, prescaler width; base tick period is 2^PRESC_W clk cycles
- PER_W, 6, width of each channel period field, in base ticks

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- pause  in  1  freezes the prescaler and channel counters while high
- period  in  NUM_CH*PER_W  channel i period at bits [i*PER_W +: PER_W]; 0 = channel disabled
- upd_ready  in  1  consumer accepts the current grant
- ovr_clr  in  1  clears all overrun flags
- base_tick  out  1  one-cycle pulse each prescaler wrap (suppressed while paused)
- grant_valid  out  1  grant offer valid
- grant_id  out  $clog2(NUM_CH)  channel being offered
- overrun  out  NUM_CH  sticky: a channel fired while its previous event was still pending

Behaviour:
- Reset, applied at posedge while rst=1, overrides everything:
  - prescaler=0, channel counters=0, pending=0, overrun=0
  - rr_ptr=0, FSM=IDLE, grant_valid=0, grant_id=0
- Prescaler:
  - Increments each cycle when pause=0; holds when pause=1.
  - base_tick = (prescaler==all-ones) & ~pause, combinational from the register.
  - The first base_tick occurs in the cycle after 2^PRESC_W-1 edges following reset release.
- Channel i, evaluated on an edge where base_tick=1:
  - period==0: counter forced to 0, no fire.
  - period!=0 and counter==0: fire; counter <= period-1.
  - Otherwise: counter decrements.
  - Net effect: an enabled channel fires on the first base tick after enable or reset, then every `period` base ticks.
  - A period change takes effect at the next reload.
- Fire handling:
  - A fire sets pending[i] at the same edge.
  - If pending[i] is already set and is not being accepted on that edge, overrun[i] <= 1.
  - Fire on the same edge as acceptance of channel i: pending[i] stays set, no overrun.
- Overrun clear:
  - ovr_clr clears overrun on the next edge.
  - A simultaneous new overrun wins (the bit stays set).
- Arbitration FSM, two states, all outputs registered:
  - IDLE: if pending!=0, select the first pending index searching upward from rr_ptr with wrap-around. Register grant_id, set grant_valid=1, go to OFFER. Otherwise stay.
  - OFFER: grant_id and grant_valid are held stable until upd_ready=1. On acceptance: clear pending[grant_id], rr_ptr <= grant_id+1 mod NUM_CH, grant_valid <= 0, go to IDLE.
- Latency and throughput:
  - Fire edge E gives grant_valid high after edge E+1.
  - Maximum throughput is one grant per 2 cycles.
- pause does not stop arbitration; pending events still drain.
- upd_ready sampled while grant_valid=0 is ignored.
- rst asserted mid-offer drops the grant; no pending event survives reset.

Decomposition:
- Shared package (tick_pkg):
  - NUM_CH default
  - CH_W = $clog2(NUM_CH)
  - FSM state enum {IDLE, OFFER}
- Sub-module rr_arbiter:
  - Combinational round-robin pick: inputs pending and rr_ptr; outputs any and idx.
  - Instantiated once by tick_scheduler.

Test Plan (PRESC_W=2, PER_W=4, NUM_CH=4 unless stated):
- Reset then free run, pause=0 -> base_tick high after edges 3, 7, 11, … (every 4 cycles); all outputs 0 during and right after reset.
- period={0,0,2,1}, upd_ready=1 -> both ch0 and ch1 fire at edge 4:
  - grant_id=0 after edge 5, grant_id=1 after edge 7.
  - Thereafter ch0 is granted once per 4 cycles and ch1 once per 8 cycles; overrun stays 0.
- All four channels with period=1, upd_ready=1 -> grant order 0,1,2,3,0,…, each offered for one cycle with one idle cycle between.
- ch0 period=1, upd_ready=0 -> grant_valid=1 with id 0 held stable, and overrun[0]=1 after the second fire (edge 8). Then ovr_clr=1 for one cycle -> overrun[0]=0, set again at the next fire.
- pause=1 for 10 cycles mid-run -> no base_tick and counters frozen, but a pending grant is still accepted. The fire schedule resumes shifted by exactly 10 cycles.
- rst=1 while grant_valid=1 -> after the edge, grant_valid=0, pending=0, overrun=0, and the next base_tick occurs 4 cycles after release.

Source files
------------

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants and types for the tick scheduler
package tick_pkg;

  localparam int NUM_CH_DFLT = 4;
  localparam int CH_W = $clog2(NUM_CH_DFLT);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first pending channel at or after ptr
module rr_arbiter
  import tick_pkg::*;
#(
  parameter int N = NUM_CH_DFLT,
  parameter int W = CH_W
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  // Descending loops leave the lowest qualifying index as the final assignment:
  // first search [ptr, N-1], then wrap to [0, ptr-1].
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pending[j] && (j >= int'(ptr))) begin
        any = 1'b1;
        idx = W'(j);
      end
    end
    if (!any) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (pending[j]) begin
          any = 1'b1;
          idx = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - prescaled periodic tick channels arbitrated onto one grant handshake
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DFLT,
  parameter int PRESC_W = 17,
  parameter int PER_W   = 6,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause,
  input  logic [NUM_CH*PER_W-1:0] period,
  input  logic                    upd_ready,
  input  logic                    ovr_clr,
  output logic                    base_tick,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_id,
  output logic [NUM_CH-1:0]       overrun
);

  logic [PRESC_W-1:0] presc;
  logic [PER_W-1:0]   cnt [NUM_CH];
  logic [NUM_CH-1:0]  fire;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  acc_vec;
  logic               accept;
  logic               arb_any;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      rr_n;
  logic [IW-1:0]      gid_n;
  logic               gv_n;
  state_t             state;
  state_t             state_n;

  assign base_tick = (&presc) & ~pause;
  assign accept    = (state == OFFER) & upd_ready;

  always_comb begin
    fire    = '0;
    acc_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i]    = base_tick && (period[i*PER_W +: PER_W] != '0) && (cnt[i] == '0);
      acc_vec[i] = accept && (grant_id == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (!pause) begin
      presc <= presc + 1'b1;
    end
  end

  // A disabled channel is parked at zero so it fires on the first tick after enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (base_tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (period[i*PER_W +: PER_W] == '0) begin
          cnt[i] <= '0;
        end else if (cnt[i] == '0) begin
          cnt[i] <= period[i*PER_W +: PER_W] - 1'b1;
        end else begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~acc_vec) | fire;
      overrun <= (ovr_clr ? '0 : overrun) | (fire & pending & ~acc_vec);
    end
  end

  rr_arbiter #(
    .N(NUM_CH),
    .W(IW)
  ) u_arb (
    .pending(pending),
    .ptr    (rr_ptr),
    .any    (arb_any),
    .idx    (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_n;
      grant_valid <= gv_n;
      grant_id    <= gid_n;
      rr_ptr      <= rr_n;
    end
  end

  always_comb begin
    state_n = state;
    gv_n    = grant_valid;
    gid_n   = grant_id;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (arb_any) begin
          state_n = OFFER;
          gv_n    = 1'b1;
          gid_n   = arb_idx;
        end
      end
      OFFER: begin
        if (upd_ready) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          rr_n    = (grant_id == IW'(NUM_CH - 1)) ? '0 : grant_id + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - scoreboard bench for tick_scheduler with directed scenarios
module tb_tick_scheduler;

  localparam int NCH  = 4;
  localparam int PW   = 2;
  localparam int PERW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pause = 1'b0;
  logic               upd_ready = 1'b0;
  logic               ovr_clr = 1'b0;
  logic [NCH*PERW-1:0] period = '0;
  logic               base_tick;
  logic               grant_valid;
  logic [1:0]         grant_id;
  logic [NCH-1:0]     overrun;

  typedef struct {
    int cyc;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_gv = 1'b0;
  int   held_id = 0;

  tick_scheduler #(
    .NUM_CH (NCH),
    .PRESC_W(PW),
    .PER_W  (PERW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .period     (period),
    .upd_ready  (upd_ready),
    .ovr_clr    (ovr_clr),
    .base_tick  (base_tick),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // cyc = number of posedges since reset release, as seen at the following negedge
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int id);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic to_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("to_cyc", cyc, n);
  endtask

  task automatic drain_chk(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mon_grant();
    exp_t e;
    if (grant_valid && !prev_gv) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_extra: got id %0d at cyc %0d expected no grant", grant_id, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", int'(grant_id), e.id);
        chk("grant_cyc", cyc, e.cyc);
        held_id = e.id;
      end
    end else if (grant_valid && prev_gv) begin
      chk("grant_hold", int'(grant_id), held_id);
    end
  endtask

  always @(negedge clk) begin
    mon_grant();
    prev_gv <= grant_valid;
  end

  initial begin
    // Reset state and free-running base tick
    period = '0;
    do_reset();
    chk("rst_base_tick", int'(base_tick), 0);
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_overrun", int'(overrun), 0);
    for (int n = 1; n <= 12; n++) begin
      to_cyc(n);
      chk("base_tick", int'(base_tick), (n % 4 == 3) ? 1 : 0);
    end

    // ch0 period 1, ch1 period 2, consumer always ready
    period    = 16'h0021;
    upd_ready = 1'b1;
    push(5, 0);  push(7, 1);  push(9, 0);
    push(13, 1); push(15, 0); push(17, 0);
    push(21, 1); push(23, 0); push(25, 0);
    do_reset();
    to_cyc(26);
    chk("mixed_overrun", int'(overrun), 0);
    drain_chk("mixed_drain");

    // All channels period 1: continuous round-robin stream
    period = 16'h1111;
    push(5, 0);  push(7, 1);  push(9, 2);  push(11, 3);
    push(13, 0); push(15, 1); push(17, 2); push(19, 3); push(21, 0);
    do_reset();
    to_cyc(9);
    chk("all_overrun", int'(overrun), 4'b1100);
    to_cyc(22);
    drain_chk("all_drain");

    // Stalled consumer: overrun set, cleared, and clear losing to a new overrun
    period    = 16'h0001;
    upd_ready = 1'b0;
    push(5, 0); push(17, 0);
    do_reset();
    to_cyc(6);
    chk("stall_valid", int'(grant_valid), 1);
    to_cyc(7);
    chk("stall_ovr_pre", int'(overrun), 0);
    to_cyc(8);
    chk("stall_ovr_set", int'(overrun), 1);
    ovr_clr = 1'b1;
    to_cyc(9);
    ovr_clr = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);
    to_cyc(11);
    chk("ovr_still_clear", int'(overrun), 0);
    ovr_clr = 1'b1;
    to_cyc(12);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    chk("stall_valid_12", int'(grant_valid), 1);
    upd_ready = 1'b1;
    to_cyc(13);
    chk("stall_accepted", int'(grant_valid), 0);
    to_cyc(19);
    drain_chk("stall_drain");

    // Pause for 10 edges while a grant is outstanding
    period    = 16'h0001;
    upd_ready = 1'b0;
    push(5, 0); push(19, 0); push(23, 0);
    do_reset();
    to_cyc(6);
    pause = 1'b1;
    for (int n = 7; n <= 16; n++) begin
      to_cyc(n);
      chk("pause_no_tick", int'(base_tick), 0);
      if (n == 9) upd_ready = 1'b1;
      if (n == 10) chk("pause_accept", int'(grant_valid), 0);
    end
    pause = 1'b0;
    to_cyc(17);
    chk("resume_tick", int'(base_tick), 1);
    to_cyc(18);
    chk("resume_tick_off", int'(base_tick), 0);
    to_cyc(21);
    chk("resume_tick2", int'(base_tick), 1);
    to_cyc(24);
    drain_chk("pause_drain");

    // Reset asserted while a grant is offered
    period    = 16'h0001;
    upd_ready = 1'b0;
    push(5, 0);
    do_reset();
    to_cyc(8);
    chk("pre_rst_valid", int'(grant_valid), 1);
    chk("pre_rst_overrun", int'(overrun), 1);
    push(5, 0);
    do_reset();
    chk("mid_rst_valid", int'(grant_valid), 0);
    chk("mid_rst_id", int'(grant_id), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    for (int n = 1; n <= 4; n++) begin
      to_cyc(n);
      chk("post_rst_valid", int'(grant_valid), 0);
      chk("post_rst_tick", int'(base_tick), (n == 3) ? 1 : 0);
    end
    to_cyc(6);
    drain_chk("rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
